// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and the command-error rule
// for the two-requester ALU arbiter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8,
    OP_NOT = 4'd9
  } alu_op_e;

  localparam logic [3:0] OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } arb_state_e;

  // Divide by zero and unknown opcodes never reach the ALU.
  function automatic logic is_bad_cmd(input logic [3:0] op, input logic [7:0] b);
    return ((op == OP_DIV) && (b == 8'd0)) || (op > OP_MAX);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the arbiter, bundled with
// a slave view (the arbiter) and a master view (requesters plus ALU).
interface alu_arbiter_if;

  logic [1:0] req_valid;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [3:0] req0_op;
  logic [3:0] req1_op;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_err;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_do;
  logic [7:0] alu_result;

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    input  rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_err,
    output alu_a, alu_b, alu_op, alu_do
  );

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    output rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
    input  alu_a, alu_b, alu_op, alu_do
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external registered ALU between two requesters, one command in
// flight at a time, with per-requester response handshakes.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  arb_state_e state;
  logic       pointer;
  logic [1:0] owner;
  logic [1:0] grant;
  logic       accept;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic [3:0] sel_op;

  rr_arb2 u_rr_arb2 (
    .req     (bus.req_valid),
    .pointer (pointer),
    .grant   (grant)
  );

  // req_ready is combinational, so it is also masked while reset is held.
  assign accept        = (state == IDLE) && !reset && (grant != 2'b00);
  assign bus.req_ready = accept ? grant : 2'b00;

  assign sel_a  = grant[1] ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant[1] ? bus.req1_b  : bus.req0_b;
  assign sel_op = grant[1] ? bus.req1_op : bus.req0_op;

  // ALU operand registers load only on issue, so they hold across error commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pointer        <= 1'b0;
      owner          <= 2'b00;
      bus.rsp_valid  <= 2'b00;
      bus.rsp_result <= 8'd0;
      bus.rsp_err    <= 1'b0;
      bus.alu_a      <= 8'd0;
      bus.alu_b      <= 8'd0;
      bus.alu_op     <= 4'd0;
      bus.alu_do     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pointer <= grant[0];
            owner   <= grant;
            if (is_bad_cmd(sel_op, sel_b)) begin
              bus.rsp_valid  <= grant;
              bus.rsp_result <= 8'd0;
              bus.rsp_err    <= 1'b1;
              state          <= RESPOND;
            end else begin
              bus.alu_a  <= sel_a;
              bus.alu_b  <= sel_b;
              bus.alu_op <= sel_op;
              bus.alu_do <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.alu_do <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_err    <= 1'b0;
          bus.rsp_valid  <= owner;
          state          <= RESPOND;
        end
        RESPOND: begin
          if ((bus.rsp_ready & owner) != 2'b00) begin
            bus.rsp_valid <= 2'b00;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random commands, checked
// against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   favour = 0;
  logic [19:0] model_alu_regs = 20'd0;
  logic [7:0]  last_result;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return 8'((16'(a) * 16'(b)) & 16'hFF);
      4'd3:    return (b == 8'd0) ? 8'd0 : a / b;
      4'd4:    return a << b[2:0];
      4'd5:    return a >> b[2:0];
      4'd6:    return a & b;
      4'd7:    return a | b;
      4'd8:    return a ^ b;
      4'd9:    return ~a;
      default: return 8'd0;
    endcase
  endfunction

  // External registered ALU: result appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.alu_do) bus.alu_result <= alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
  end

  function automatic logic [1:0] expected_grant(input logic [1:0] v, input int fav);
    if (v == 2'b11) return (fav == 1) ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command: present, accept, issue/wait (unless error), respond
  // with 'hold' stalled cycles, then consume.
  task automatic apply_stimulus(input string tag, input logic [1:0] valid,
                                input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] op0,
                                input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] op1,
                                input int hold);
    logic [1:0] g;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] eop;
    logic       err;
    logic [7:0] exp_res;
    bus.req_valid = valid;
    bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    bus.rsp_ready = 2'b00;
    g = expected_grant(valid, favour);
    ea  = g[1] ? a1 : a0;
    eb  = g[1] ? b1 : b0;
    eop = g[1] ? op1 : op0;
    err = ((eop == 4'd3) && (eb == 8'd0)) || (eop > 4'd9);
    exp_res = err ? 8'd0 : alu_model(ea, eb, eop);
    #1;
    check_output({tag, "/accept"}, 64'(bus.req_ready), 64'(g));
    favour = g[0] ? 1 : 0;
    tick();
    bus.req_valid = 2'b11;
    #1;
    if (!err) begin
      check_output({tag, "/issue"}, {bus.alu_do, bus.alu_a, bus.alu_b, bus.alu_op},
                   {1'b1, ea, eb, eop});
      model_alu_regs = {ea, eb, eop};
      tick();
      check_output({tag, "/wait"}, {bus.alu_do, bus.rsp_valid, bus.req_ready}, 64'd0);
      tick();
    end else begin
      check_output({tag, "/noissue"}, {bus.alu_do, bus.alu_a, bus.alu_b, bus.alu_op},
                   {1'b0, model_alu_regs});
    end
    check_output({tag, "/rsp"}, {bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.req_ready},
                 {g, exp_res, err, 2'b00});
    last_result = bus.rsp_result;
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = (i % 2 == 1) ? ~g : 2'b00;
      tick();
      check_output({tag, "/hold"}, {bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.req_ready},
                   {g, exp_res, err, 2'b00});
    end
    bus.rsp_ready = g | (($urandom % 2 == 1) ? ~g : 2'b00);
    #1;
    check_output({tag, "/consume_noacc"}, 64'(bus.req_ready), 64'd0);
    tick();
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b00;
    #1;
    check_output({tag, "/done"}, {bus.rsp_valid, bus.req_ready}, 64'd0);
  endtask

  initial begin
    bus.req_valid = 2'b11;
    bus.req0_a = 8'h11; bus.req0_b = 8'h22; bus.req0_op = 4'd0;
    bus.req1_a = 8'h33; bus.req1_b = 8'h44; bus.req1_op = 4'd0;
    bus.rsp_ready = 2'b11;
    bus.alu_result = 8'd0;
    tick();
    tick();
    check_output("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_err,
                 bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_do}, 64'd0);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    #2 reset = 1'b0;
    favour = 0;
    tick();

    // Joint requests alternate, starting with requester 0.
    apply_stimulus("rr1", 2'b11, 8'd9, 8'd4, 4'd1, 8'hF0, 8'h3C, 4'd6, 0);
    check_output("rr1_value", 64'(last_result), 64'd5);
    apply_stimulus("rr2", 2'b11, 8'd9, 8'd4, 4'd1, 8'hF0, 8'h3C, 4'd6, 0);
    check_output("rr2_value", 64'(last_result), 64'h30);
    apply_stimulus("rr3", 2'b11, 8'd9, 8'd4, 4'd1, 8'hF0, 8'h3C, 4'd6, 0);

    apply_stimulus("add", 2'b01, 8'd5, 8'd3, 4'd0, 8'd0, 8'd0, 4'd0, 0);
    check_output("add_value", 64'(last_result), 64'd8);
    apply_stimulus("div0", 2'b10, 8'd0, 8'd0, 4'd0, 8'd7, 8'd0, 4'd3, 0);
    apply_stimulus("badop", 2'b01, 8'd1, 8'd2, 4'hC, 8'd0, 8'd0, 4'd0, 0);
    apply_stimulus("stall", 2'b01, 8'd20, 8'd6, 4'd1, 8'd0, 8'd0, 4'd0, 5);

    // Reset while the command sits in WAIT drops it entirely.
    bus.req_valid = 2'b01;
    bus.req0_a = 8'd2; bus.req0_b = 8'd3; bus.req0_op = 4'd2;
    #1;
    check_output("rst_accept", 64'(bus.req_ready), 64'(expected_grant(2'b01, favour)));
    tick();
    bus.req_valid = 2'b11;
    tick();
    #2 reset = 1'b1;
    #1;
    check_output("rst_in_wait", {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_err,
                 bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_do}, 64'd0);
    tick();
    bus.req_valid = 2'b00;
    #2 reset = 1'b0;
    favour = 0;
    model_alu_regs = 20'd0;
    tick();
    tick();
    check_output("rst_no_rsp", {bus.rsp_valid, bus.alu_do}, 64'd0);
    apply_stimulus("after_rst", 2'b11, 8'd40, 8'd2, 4'd0, 8'd1, 8'd1, 4'd0, 1);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra0, rb0, ra1, rb1;
      logic [3:0] rop0, rop1;
      ra0 = 8'($urandom); ra1 = 8'($urandom);
      rb0 = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
      rb1 = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
      rop0 = 4'($urandom_range(0, 11));
      rop1 = 4'($urandom_range(0, 11));
      apply_stimulus("rand", 2'($urandom_range(1, 3)), ra0, rb0, rop0, ra1, rb1, rop1,
                     $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports as follows.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester command valid; bit n belongs to requester n.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
REQ-006 req0_op, req1_op  input  4 each  ALU operation code.
REQ-007 req_ready  output  2  per-requester accept strobe.
REQ-008 rsp_valid  output  2  per-requester response valid.
REQ-009 rsp_ready  input  2  per-requester response accept.
REQ-010 rsp_result  output  8  shared response data, valid for the requester whose rsp_valid bit is set.
REQ-011 rsp_err  output  1  response error flag, qualified like rsp_result.
REQ-012 alu_a, alu_b  output  8 each  operands to the shared ALU.
REQ-013 alu_op  output  4  operation code to the shared ALU.
REQ-014 alu_do  output  1  one-cycle operation strobe to the ALU.
REQ-015 alu_result  input  8  ALU registered result, valid the cycle after the alu_do cycle.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESPOND; exactly one command is in flight at a time.
REQ-017 IDLE: if any req_valid bit is set, grant one requester, latch its a/b/op, assert its req_ready bit combinationally for that cycle only, and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; the priority pointer updates only on a grant.
REQ-019 req_ready SHALL be 0 in every state other than IDLE and SHALL never have both bits set.
REQ-020 ISSUE: drive alu_a/alu_b/alu_op from the latched values with alu_do=1 for exactly one cycle, then go to WAIT.
REQ-021 WAIT: capture alu_result into the response register with rsp_err=0, then go to RESPOND.
REQ-022 A latched op of 4'b0011 with b==0, or any op above 4'b1001, SHALL be an error: skip ISSUE/WAIT, go straight from IDLE to RESPOND with rsp_result=0, rsp_err=1, and alu_do never asserted.
REQ-023 RESPOND: assert rsp_valid for the granted requester only, holding rsp_result/rsp_err stable until that requester's rsp_ready is 1 at a clock edge, then go to IDLE.
REQ-024 rsp_ready bits of the non-granted requester SHALL be ignored.
REQ-025 Latency SHALL be: accepted in cycle T, alu_do in T+1, rsp_valid from T+3 for a normal command, and from T+1 for an error command.
REQ-026 alu_a/alu_b/alu_op SHALL hold their last values while alu_do=0.
REQ-027 A new command SHALL NOT be accepted in the cycle a response is consumed; the earliest next accept is the following IDLE cycle.

Reset
REQ-028 Asserting reset in any state SHALL immediately force state=IDLE; req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_op and alu_do all 0; priority pointer to requester 0; any in-flight command is dropped.
REQ-029 The first cycle after reset deassertion SHALL behave as IDLE with requester 0 favoured.

Structure
REQ-030 Operation-code constants (ADD=0 through NOT=9, DIV=3, OP_MAX=9) and the state encoding SHALL live in a shared package, alu_pkg.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs req[1:0], pointer; output grant[1:0]); the ALU itself stays outside this block.

Verification
REQ-032 req0: a=5, b=3, op=0; ALU model returns 8 -> req_ready=01 in T, alu_do in T+1, rsp_valid=01 with rsp_result=8, rsp_err=0 from T+3.
REQ-033 Both valid after reset: req0 op=1 (9-4), req1 op=6 (F0&3C) -> requester 0 first with result 5, then requester 1 with result 0x30; a third joint request goes to requester 0.
REQ-034 req1: a=7, b=0, op=3 -> rsp_valid=10, rsp_result=0, rsp_err=1 from T+1; alu_do stays 0.
REQ-035 req0 op=4'b1100 -> rsp_err=1, rsp_result=0, no alu_do.
REQ-036 rsp_ready held 0 for 5 cycles in RESPOND, with rsp_ready[1] pulsed for a requester-0 response -> rsp_valid and data stay stable; no new accept occurs until rsp_ready[0]=1.
REQ-037 Reset asserted in WAIT -> all outputs 0 immediately, no response for the dropped command, next request is served normally.
